cp0_unit: RTL
=============

Name: cp0_unit

Overview:
- Parametrised coprocessor-0 for the MIPS54 core: holds Status, Cause, EPC, Count and Compare.
- Arbitrates synchronous exceptions (syscall/break/teq) and external hardware interrupts.
- Drives the trap/eret redirect PC to the fetch stage.
- Successor to the single-cycle CP0: adds EXL-based nesting, masked vectored interrupts with synchronisers, a Count/Compare timer and a configurable vector.

Parameters:
- NUM_IRQ, 6, number of external interrupt lines (1..6), mapped to Cause.IP[NUM_IRQ+1:2].
- EXC_VECTOR, 32'h0000_0004, trap entry PC.
- CNT_DIV, 2, core clocks per Count increment (>=1).
- SYNC_STAGES, 2, flops on each irq_in line (>=2).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- mfc0, in, 1, read strobe; informational, read path is combinational.
- mtc0, in, 1, write cp0[addr] <= wdata.
- addr, in, 5, register index.
- wdata, in, 32, mtc0 data.
- rdata, out, 32, cp0[addr]; unimplemented indices read 0.
- pc, in, 32, PC of the current instruction, captured into EPC on a trap.
- exc_req, in, 1, synchronous exception request.
- exc_code, in, 5, ExcCode for exc_req: 8 Sys, 9 Bp, 13 Tr.
- eret, in, 1, return from exception.
- irq_in, in, NUM_IRQ, asynchronous level interrupts.
- trap, out, 1, combinational; a trap is taken this cycle.
- redirect, out, 1, trap | eret_ok.
- redirect_pc, out, 32, EXC_VECTOR when trap, EPC when eret_ok, else EXC_VECTOR.
- timer_irq, out, 1, Cause.IP[7].

Behaviour:
- Reset: all registers 0, synchronisers 0, divider 0. Outputs: rdata=0, trap=0, redirect=0, redirect_pc=EXC_VECTOR, timer_irq=0.
- Status(12): bit0 IE, bit1 EXL, [15:8] IM; all other bits read 0, writes ignored.
- Cause(13): [6:2] ExcCode, [15:8] IP; read-only to mtc0.
- EPC(14), Count(9), Compare(11): full 32 bits, writable.
- IP[NUM_IRQ+1:2] = synchronised irq_in; IP[7] = timer latch; IP[1:0] = 0. IP bits not driven read 0.
- int_pend = IE & ~EXL & |(IP & IM).
- trap = ~EXL & (exc_req | int_pend). exc_req with EXL=1 is ignored.
- Priority: exc_req over interrupt.
- On the trap edge:
  - EXL <= 1.
  - EPC <= pc.
  - ExcCode <= exc_code for an exception, 0 for an interrupt.
  - IE is unchanged.
- eret_ok = eret & EXL & ~trap. On that edge EXL <= 0. eret with EXL=0 is a no-op, and redirect stays 0.
- Simultaneous events:
  - trap overrides mtc0 to Status/Cause/EPC in the same cycle; the mtc0 is dropped.
  - mtc0 to other addresses still commits.
  - mtc0 and eret together: mtc0 commits and EXL clears. If the mtc0 writes Status, the written EXL is overridden to 0.
- rdata is combinational and shows pre-edge values, with no write-forwarding.
- Count increments once every CNT_DIV clocks and wraps 32'hFFFF_FFFF -> 0.
- mtc0 Count loads wdata and resets the divider.
- Timer: when Count == Compare and Compare != 0, set IP[7] (sticky). mtc0 Compare clears IP[7].
- The interrupt path latency from an irq_in edge to int_pend is exactly SYNC_STAGES clocks.
- Reset asserted mid-trap: the state returns to reset values immediately and no redirect occurs.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: Count/Compare/timer as described.
- Undefined: Count and Compare read 0 and ignore writes, IP[7]=0, timer_irq=0, and no divider logic is generated.

Decomposition:
- Package cp0_pkg:
  - Register index constants: CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14.
  - ExcCode constants: EXC_INT=0, EXC_SYS=8, EXC_BP=9, EXC_TR=13.
  - Status bit positions.
- Sub-module cp0_timer (Count, divider, Compare match, IP[7] latch) is natural; it is instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset, then mtc0 Status=32'h0000_FF01, exc_req=1, exc_code=8, pc=32'h0040_0010 -> trap=1, redirect_pc=32'h4; next cycle EPC=32'h0040_0010, Cause[6:2]=8, Status.EXL=1.
- Same state, eret=1 -> redirect=1, redirect_pc=32'h0040_0010; next cycle EXL=0. A second eret -> redirect=0.
- IM=8'h04, IE=1, raise irq_in[0] -> trap exactly 2 clocks later with ExcCode=0. With IM=0 there is no trap, but Cause.IP[2] reads 1.
- EXL=1 with exc_req=1 -> trap=0 and EPC unchanged. Simultaneous exc_req and irq -> ExcCode = exc_code.
- CP0_TIMER_EN: Compare=5, Count=0, CNT_DIV=2 -> IP[7] sets after 10 clocks; mtc0 Compare clears it. Count=32'hFFFF_FFFF wraps to 0.
- Assert rst during the trap cycle -> all registers 0, redirect=0, rdata(12)=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register indices, exception codes and Status bit positions
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_BP  = 5'd9;
    localparam logic [4:0] EXC_TR  = 5'd13;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    function automatic logic [31:0] status_word(input logic ie, input logic exl,
                                                input logic [7:0] im);
        logic [31:0] w;
        w = '0;
        w[ST_IE]              = ie;
        w[ST_EXL]             = exl;
        w[ST_IM_HI:ST_IM_LO]  = im;
        return w;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with clock divider and sticky IP[7] latch
module cp0_timer #(
    parameter int CNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_ip_o
);
    localparam int DW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [31:0]   count_q, count_d, compare_q;
    logic          ip_q;
    logic          inc;

    always_comb begin
        inc     = (div_q == DW'(CNT_DIV - 1));
        div_d   = inc ? '0 : div_q + 1'b1;
        count_d = count_q + {31'b0, inc};
        if (count_we_i) begin
            count_d = wdata_i;
            div_d   = '0;
        end
    end

    // Match is taken on the value Count is about to hold, so IP[7] rises on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            ip_q      <= 1'b0;
        end else begin
            div_q   <= div_d;
            count_q <= count_d;
            if (compare_we_i) begin
                compare_q <= wdata_i;
                ip_q      <= 1'b0;
            end else if (count_d == compare_q && compare_q != 32'd0) begin
                ip_q <= 1'b1;
            end
        end
    end

    assign count_o    = count_q;
    assign compare_o  = compare_q;
    assign timer_ip_o = ip_q;

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MIPS54 coprocessor 0: Status/Cause/EPC, trap/eret redirect, IRQ sync; timer under CP0_TIMER_EN
module cp0_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ     = 6,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0004,
    parameter int          CNT_DIV     = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mfc0,
    input  logic               mtc0,
    input  logic [4:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    input  logic [31:0]        pc,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic               eret,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               trap,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic               timer_irq
);
    logic               ie_q, exl_q;
    logic [7:0]         im_q;
    logic [4:0]         exccode_q;
    logic [31:0]        epc_q;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [31:0]        count, compare;
    logic               timer_ip;
    logic [7:0]         ip;
    logic               int_pend, eret_ok;
    logic               unused_mfc0;

    assign unused_mfc0 = mfc0;

`ifdef CP0_TIMER_EN
    cp0_timer #(.CNT_DIV(CNT_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (mtc0 && addr == CP0_COUNT),
        .compare_we_i (mtc0 && addr == CP0_COMPARE),
        .wdata_i      (wdata),
        .count_o      (count),
        .compare_o    (compare),
        .timer_ip_o   (timer_ip)
    );
`else
    assign count    = 32'd0;
    assign compare  = 32'd0;
    assign timer_ip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    always_comb begin
        ip                = '0;
        ip[NUM_IRQ+1:2]   = sync_q[SYNC_STAGES-1];
        ip[7]             = ip[7] | timer_ip;
    end

    // Reset gates the trap so an in-flight exception never redirects fetch.
    assign int_pend    = ie_q & ~exl_q & (|(ip & im_q));
    assign trap        = ~rst & ~exl_q & (exc_req | int_pend);
    assign eret_ok     = ~rst & eret & exl_q & ~trap;
    assign redirect    = trap | eret_ok;
    assign redirect_pc = eret_ok ? epc_q : EXC_VECTOR;
    assign timer_irq   = ip[7];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            im_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else if (trap) begin
            exl_q     <= 1'b1;
            epc_q     <= pc;
            exccode_q <= exc_req ? exc_code : EXC_INT;
        end else begin
            if (mtc0 && addr == CP0_STATUS) begin
                ie_q  <= wdata[ST_IE];
                exl_q <= wdata[ST_EXL];
                im_q  <= wdata[ST_IM_HI:ST_IM_LO];
            end
            if (mtc0 && addr == CP0_EPC) epc_q <= wdata;
            if (eret_ok) exl_q <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            CP0_STATUS:  rdata = status_word(ie_q, exl_q, im_q);
            CP0_CAUSE:   rdata = {16'b0, ip, 1'b0, exccode_q, 2'b0};
            CP0_EPC:     rdata = epc_q;
            CP0_COUNT:   rdata = count;
            CP0_COMPARE: rdata = compare;
            default:     rdata = '0;
        endcase
    end

endmodule
